// File: rtl/output_frame_scheduler.sv
// Double-buffered per-tick spike bitmap with a word-serial valid/ready drain.
// One bank captures spikes while the other is streamed out and cleared word by word.
module output_frame_scheduler #(
    parameter int NUM_OUTPUTS    = 256,
    parameter int WORD_WIDTH     = 32,
    parameter int TICK_CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic [$clog2(NUM_OUTPUTS)-1:0] packet_in,
    input  logic                           packet_in_valid,
    output logic [WORD_WIDTH-1:0]          m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    output logic [TICK_CNT_WIDTH-1:0]      m_tick,
    output logic                           busy,
    output logic                           overrun_error,
    input  logic                           error_clear
);

    localparam int NWORDS = NUM_OUTPUTS / WORD_WIDTH;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                    state, state_next;
    logic                      sel;
    logic [IDX_W-1:0]          idx;
    logic [TICK_CNT_WIDTH-1:0] tick_count;
    logic [NUM_OUTPUTS-1:0]    bank0, bank1;
    logic [NUM_OUTPUTS-1:0]    cap_mask, clr_mask;
    logic [WORD_WIDTH-1:0]     drain_word;
    logic                      capture, handshake, last_word;
    logic                      accept_tick, overrun_set;

    assign capture     = packet_in_valid && (32'(packet_in) < 32'(NUM_OUTPUTS));
    assign last_word   = (idx == IDX_W'(NWORDS - 1));
    assign handshake   = (state == SEND) && m_ready;
    assign accept_tick = (state == IDLE) && tick;
    assign overrun_set = (state == SEND) && tick;

    assign m_valid = (state == SEND);
    assign busy    = (state == SEND);
    assign m_last  = (state == SEND) && last_word;
    assign m_data  = (state == SEND) ? drain_word : '0;

    // sel names the capture bank; the drain bank is always the other one.
    always_comb begin
        cap_mask   = '0;
        clr_mask   = '0;
        drain_word = '0;
        if (capture) begin
            cap_mask[packet_in] = 1'b1;
        end
        for (int unsigned w = 0; w < NWORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                drain_word = sel ? bank0[w*WORD_WIDTH +: WORD_WIDTH]
                                 : bank1[w*WORD_WIDTH +: WORD_WIDTH];
                if (handshake) begin
                    clr_mask[w*WORD_WIDTH +: WORD_WIDTH] = '1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (tick) state_next = SEND;
            SEND: if (handshake && last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank0         <= '0;
            bank1         <= '0;
            sel           <= 1'b0;
            idx           <= '0;
            tick_count    <= '0;
            m_tick        <= '0;
            overrun_error <= 1'b0;
        end else begin
            // Capture targets the pre-swap bank, so a same-cycle packet joins the ending tick.
            if (!sel) begin
                bank0 <= bank0 | cap_mask;
                bank1 <= bank1 & ~clr_mask;
            end else begin
                bank1 <= bank1 | cap_mask;
                bank0 <= bank0 & ~clr_mask;
            end

            if (accept_tick) begin
                sel        <= ~sel;
                m_tick     <= tick_count;
                tick_count <= tick_count + 1'b1;
                idx        <= '0;
            end else if (handshake && !last_word) begin
                idx <= idx + 1'b1;
            end

            if (overrun_set) begin
                overrun_error <= 1'b1;
            end else if (error_clear) begin
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_frame_scheduler.sv
// Directed bench for output_frame_scheduler: frame contents, stalls, overrun and tick wrap.
module tb_output_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst, tick, packet_in_valid, m_ready, error_clear;
    logic [7:0]  packet_in;
    logic [31:0] m_data;
    logic        m_valid, m_last, busy, overrun_error;
    logic [15:0] m_tick;

    logic        tick2;
    logic [31:0] m_data2;
    logic        m_valid2, m_last2, busy2, overrun_error2;
    logic [1:0]  m_tick2;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_words [8];
    int wrap_exp [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    output_frame_scheduler #(.NUM_OUTPUTS(256), .WORD_WIDTH(32), .TICK_CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .packet_in(packet_in),
        .packet_in_valid(packet_in_valid), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .m_tick(m_tick), .busy(busy),
        .overrun_error(overrun_error), .error_clear(error_clear)
    );

    output_frame_scheduler #(.NUM_OUTPUTS(256), .WORD_WIDTH(32), .TICK_CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick2), .packet_in(8'd0),
        .packet_in_valid(1'b0), .m_data(m_data2), .m_valid(m_valid2),
        .m_ready(1'b1), .m_last(m_last2), .m_tick(m_tick2), .busy(busy2),
        .overrun_error(overrun_error2), .error_clear(1'b0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic zero_words();
        for (int i = 0; i < 8; i++) exp_words[i] = '0;
    endtask

    // Expects SEND at word 0 with m_ready high; drains and checks all 8 words.
    task automatic check_frame(input logic [15:0] exp_tick);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("valid_w%0d", i), m_valid, 1);
            chk($sformatf("data_w%0d", i), m_data, exp_words[i]);
            chk($sformatf("last_w%0d", i), m_last, (i == 7));
            chk($sformatf("tick_w%0d", i), m_tick, exp_tick);
            step();
        end
        chk("valid_after_frame", m_valid, 0);
        chk("busy_after_frame", busy, 0);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] idx);
        packet_in_valid = 1'b1;
        packet_in = idx;
        step();
        packet_in_valid = 1'b0;
    endtask

    initial begin
        int e;
        rst = 1'b1; tick = 1'b0; tick2 = 1'b0; packet_in_valid = 1'b0; packet_in = '0;
        m_ready = 1'b0; error_clear = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_tick", m_tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun_error, 0);

        // Basic frame with spikes in words 0, 1 and 7
        m_ready = 1'b1;
        send_pkt(8'd0); send_pkt(8'd33); send_pkt(8'd255);
        pulse_tick();
        zero_words();
        exp_words[0] = 32'h0000_0001;
        exp_words[1] = 32'h0000_0002;
        exp_words[7] = 32'h8000_0000;
        check_frame(16'd0);

        // Same-cycle packet joins ending tick; tick one cycle after last handshake
        packet_in_valid = 1'b1; packet_in = 8'd5; tick = 1'b1;
        step();
        tick = 1'b0; packet_in = 8'd6;
        chk("same_cycle_data", m_data, 32'h0000_0020);
        chk("same_cycle_tick", m_tick, 1);
        chk("same_cycle_busy", busy, 1);
        step();
        packet_in_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("f1_data_w%0d", i), m_data, 0);
            step();
        end
        chk("f1_done", m_valid, 0);
        pulse_tick();
        zero_words();
        exp_words[0] = 32'h0000_0040;
        check_frame(16'd2);

        // Stall pattern 1,0,0,1 repeated
        send_pkt(8'd1); send_pkt(8'd40);
        pulse_tick();
        zero_words();
        exp_words[0] = 32'h0000_0002;
        exp_words[1] = 32'h0000_0100;
        e = 0;
        for (int c = 0; c < 40 && e < 8; c++) begin
            m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            chk($sformatf("stall_valid_c%0d", c), m_valid, 1);
            chk($sformatf("stall_data_c%0d", c), m_data, exp_words[e]);
            chk($sformatf("stall_last_c%0d", c), m_last, (e == 7));
            chk($sformatf("stall_tick_c%0d", c), m_tick, 3);
            step();
            if (m_ready) e++;
        end
        chk("stall_words_done", e, 8);
        chk("stall_valid_after", m_valid, 0);
        m_ready = 1'b1;

        // Overrun: dropped tick's spikes merge into the next frame
        m_ready = 1'b0;
        pulse_tick();
        send_pkt(8'd10);
        pulse_tick();
        send_pkt(8'd11);
        chk("ovr_flag", overrun_error, 1);
        chk("ovr_busy", busy, 1);
        chk("ovr_data", m_data, 0);
        chk("ovr_tick", m_tick, 4);
        m_ready = 1'b1;
        zero_words();
        check_frame(16'd4);
        chk("ovr_sticky", overrun_error, 1);
        pulse_tick();
        exp_words[0] = 32'h0000_0C00;
        check_frame(16'd5);
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        chk("ovr_cleared", overrun_error, 0);

        // Set wins over a simultaneous clear
        m_ready = 1'b0;
        pulse_tick();
        tick = 1'b1; error_clear = 1'b1;
        step();
        tick = 1'b0; error_clear = 1'b0;
        chk("ovr_set_wins", overrun_error, 1);
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        chk("ovr_clear_busy", overrun_error, 0);
        m_ready = 1'b1;
        zero_words();
        check_frame(16'd6);

        // Reset in mid-frame
        send_pkt(8'd3);
        pulse_tick();
        chk("pre_rst_data", m_data, 32'h0000_0008);
        chk("pre_rst_tick", m_tick, 7);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_tick", m_tick, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun_error, 0);
        step();
        chk("post_rst_idle", m_valid, 0);
        pulse_tick();
        zero_words();
        check_frame(16'd0);

        // Tick counter wrap on the 2-bit instance
        for (int k = 0; k < 5; k++) begin
            tick2 = 1'b1;
            step();
            tick2 = 1'b0;
            chk($sformatf("wrap_tick_%0d", k), m_tick2, wrap_exp[k]);
            chk($sformatf("wrap_valid_%0d", k), m_valid2, 1);
            repeat (8) step();
            chk($sformatf("wrap_done_%0d", k), m_valid2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
